// File: rtl/alu_pkg.sv
// Shared ALU interface constants: control codes, ALUOp/funct encodings and
// the issue-stage state encoding.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] ALUCTR_ADD = 3'b000;
  localparam logic [2:0] ALUCTR_SUB = 3'b001;
  localparam logic [2:0] ALUCTR_OR  = 3'b010;
  localparam logic [2:0] ALUCTR_AND = 3'b011;
  localparam logic [2:0] ALUCTR_MUL = 3'b100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MUL_WAIT = 2'b01,
    HOLD     = 2'b10
  } state_e;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALUOp/funct decoder producing the 3-bit ALU control code.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] aluctr_o,
  output logic       illegal_o
);

  always_comb begin
    aluctr_o  = ALUCTR_ADD;
    illegal_o = 1'b0;
    case (aluop_i)
      ALUOP_ADD: aluctr_o = ALUCTR_ADD;
      ALUOP_SUB: aluctr_o = ALUCTR_SUB;
      ALUOP_OR:  aluctr_o = ALUCTR_OR;
      default: begin
        case (funct_i)
          FUNCT_ADD: aluctr_o = ALUCTR_ADD;
          FUNCT_SUB: aluctr_o = ALUCTR_SUB;
          FUNCT_OR:  aluctr_o = ALUCTR_OR;
          FUNCT_AND: aluctr_o = ALUCTR_AND;
          FUNCT_MUL: aluctr_o = ALUCTR_MUL;
          // Unknown R-type funct falls back to add and is flagged.
          default: begin
            aluctr_o  = ALUCTR_ADD;
            illegal_o = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes the ALU control code, registers operands and offers
// them downstream with valid/ready, holding MUL operands stable while the multiplier settles.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        aluop_i,
  input  logic [5:0]        funct_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic              alusrc_i,
  input  logic [4:0]        rd_i,
  input  logic              flush_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [2:0]        aluctr_o,
  output logic [4:0]        rd_o,
  output logic              illegal_o
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q;
  state_e            load_state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_load_d;
  logic [DATA_W-1:0] data1_q, data2_q, data2_d;
  logic [2:0]        aluctr_q, dec_ctr;
  logic [4:0]        rd_q;
  logic              illegal_q, dec_ill;
  logic              accept, is_mul;

  alu_ctrl_dec u_dec (
    .aluop_i   (aluop_i),
    .funct_i   (funct_i),
    .aluctr_o  (dec_ctr),
    .illegal_o (dec_ill)
  );

  assign data2_d    = alusrc_i ? imm_i : rt_data_i;
  assign in_ready_o = rst_i & ((state_q == IDLE) | ((state_q == HOLD) & out_ready_i));
  assign accept     = in_valid_i & in_ready_o & ~flush_i;
  assign is_mul     = (dec_ctr == ALUCTR_MUL);

  // A single-cycle multiplier needs no wait phase and goes straight to HOLD.
  always_comb begin
    load_state_d = HOLD;
    cnt_load_d   = '0;
    if (is_mul && (MUL_CYCLES > 1)) begin
      load_state_d = MUL_WAIT;
      cnt_load_d   = CNT_LOAD;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data1_q   <= '0;
      data2_q   <= '0;
      aluctr_q  <= ALUCTR_ADD;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (accept) begin
      state_q   <= load_state_d;
      cnt_q     <= cnt_load_d;
      data1_q   <= rs_data_i;
      data2_q   <= data2_d;
      aluctr_q  <= dec_ctr;
      rd_q      <= rd_i;
      illegal_q <= dec_ill;
    end else begin
      case (state_q)
        MUL_WAIT: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_q <= HOLD;
        end
        HOLD: begin
          if (out_ready_i) state_q <= IDLE;
        end
        IDLE: state_q <= IDLE;
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign out_valid_o = (state_q == HOLD);
  assign data1_o     = data1_q;
  assign data2_o     = data2_q;
  assign aluctr_o    = aluctr_q;
  assign rd_o        = rd_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with MUL_CYCLES=3.
module tb_alu_issue_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  aluop_i;
  logic [5:0]  funct_i;
  logic [31:0] rs_data_i, rt_data_i, imm_i;
  logic        alusrc_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        out_ready_i;
  logic        out_valid_o;
  logic [31:0] data1_o, data2_o;
  logic [2:0]  aluctr_o;
  logic [4:0]  rd_o;
  logic        illegal_o;

  int checks = 0;
  int errors = 0;

  alu_issue_stage #(.MUL_CYCLES(3), .CNT_W(2)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .aluop_i     (aluop_i),
    .funct_i     (funct_i),
    .rs_data_i   (rs_data_i),
    .rt_data_i   (rt_data_i),
    .imm_i       (imm_i),
    .alusrc_i    (alusrc_i),
    .rd_i        (rd_i),
    .flush_i     (flush_i),
    .out_ready_i (out_ready_i),
    .out_valid_o (out_valid_o),
    .data1_o     (data1_o),
    .data2_o     (data2_o),
    .aluctr_o    (aluctr_o),
    .rd_o        (rd_o),
    .illegal_o   (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] imm, input logic src,
                       input logic [4:0] rd);
    in_valid_i = 1'b1;
    aluop_i    = op;
    funct_i    = fn;
    rs_data_i  = rs;
    rt_data_i  = rt;
    imm_i      = imm;
    alusrc_i   = src;
    rd_i       = rd;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [2:0] ctr);
    chk({tag, "_valid"}, 32'(out_valid_o), 32'(v));
    chk({tag, "_data1"}, data1_o, d1);
    chk({tag, "_data2"}, data2_o, d2);
    chk({tag, "_aluctr"}, 32'(aluctr_o), 32'(ctr));
  endtask

  initial begin
    rst_i = 1'b0; in_valid_i = 1'b0; aluop_i = 2'b00; funct_i = 6'd0;
    rs_data_i = '0; rt_data_i = '0; imm_i = '0; alusrc_i = 1'b0; rd_i = '0;
    flush_i = 1'b0; out_ready_i = 1'b0;

    // Reset state
    tick(); tick();
    chk_out("rst", 1'b0, 32'h0, 32'h0, 3'b000);
    chk("rst_rd", 32'(rd_o), 32'd0);
    chk("rst_illegal", 32'(illegal_o), 32'd0);
    chk("rst_in_ready", 32'(in_ready_o), 32'd0);
    rst_i = 1'b1; #1;
    chk("idle_in_ready", 32'(in_ready_o), 32'd1);

    // 1: R-type add
    out_ready_i = 1'b1;
    drive(2'b10, 6'b100000, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3);
    tick(); in_valid_i = 1'b0;
    chk_out("add", 1'b1, 32'd5, 32'd7, 3'b000);
    chk("add_rd", 32'(rd_o), 32'd3);
    chk("add_illegal", 32'(illegal_o), 32'd0);

    // 2: MUL issued from HOLD, needs 3 cycles
    drive(2'b10, 6'b011000, 32'd6, 32'd9, 32'd0, 1'b0, 5'd4);
    #1 chk("mul_accept_ready", 32'(in_ready_o), 32'd1);
    tick(); in_valid_i = 1'b0;
    chk_out("mul_c1", 1'b0, 32'd6, 32'd9, 3'b100);
    chk("mul_c1_in_ready", 32'(in_ready_o), 32'd0);
    tick();
    chk_out("mul_c2", 1'b0, 32'd6, 32'd9, 3'b100);
    chk("mul_c2_in_ready", 32'(in_ready_o), 32'd0);
    tick();
    chk_out("mul_c3", 1'b1, 32'd6, 32'd9, 3'b100);
    chk("mul_rd", 32'(rd_o), 32'd4);

    // 3: addi with backpressure, then swap to sub
    drive(2'b00, 6'd0, 32'h0000000A, 32'd55, 32'hFFFFFFFF, 1'b1, 5'd7);
    tick();
    out_ready_i = 1'b0;
    drive(2'b01, 6'd0, 32'd100, 32'd30, 32'd1, 1'b0, 5'd8);
    #1;
    chk_out("addi", 1'b1, 32'h0000000A, 32'hFFFFFFFF, 3'b000);
    for (int i = 0; i < 4; i++) begin
      chk("bp_in_ready", 32'(in_ready_o), 32'd0);
      tick();
      chk_out("bp_hold", 1'b1, 32'h0000000A, 32'hFFFFFFFF, 3'b000);
      chk("bp_rd", 32'(rd_o), 32'd7);
    end
    out_ready_i = 1'b1; #1;
    chk("swap_in_ready", 32'(in_ready_o), 32'd1);
    tick(); in_valid_i = 1'b0;
    chk_out("sub", 1'b1, 32'd100, 32'd30, 3'b001);
    chk("sub_rd", 32'(rd_o), 32'd8);

    // 4: flush during MUL_WAIT, then flush with a same-cycle input in IDLE
    drive(2'b10, 6'b011000, 32'd2, 32'd3, 32'd0, 1'b0, 5'd9);
    tick();
    chk("fl_mulwait_valid", 32'(out_valid_o), 32'd0);
    flush_i = 1'b1;
    drive(2'b00, 6'd0, 32'd11, 32'd12, 32'd0, 1'b0, 5'd10);
    tick();
    chk("fl_idle_valid", 32'(out_valid_o), 32'd0);
    chk("fl_idle_in_ready", 32'(in_ready_o), 32'd1);
    tick();
    chk("fl_drop_valid", 32'(out_valid_o), 32'd0);
    flush_i = 1'b0;
    tick(); in_valid_i = 1'b0;
    chk_out("post_flush", 1'b1, 32'd11, 32'd12, 3'b000);
    chk("post_flush_rd", 32'(rd_o), 32'd10);

    // 5: illegal funct, cleared by the next legal op
    drive(2'b10, 6'b111111, 32'd1, 32'd2, 32'd0, 1'b0, 5'd11);
    tick();
    chk_out("ill", 1'b1, 32'd1, 32'd2, 3'b000);
    chk("ill_flag", 32'(illegal_o), 32'd1);
    drive(2'b10, 6'b100100, 32'h000000F0, 32'h0000003C, 32'd0, 1'b0, 5'd12);
    tick();
    chk_out("and", 1'b1, 32'h000000F0, 32'h0000003C, 3'b011);
    chk("and_ill_clear", 32'(illegal_o), 32'd0);
    drive(2'b11, 6'b111111, 32'd1, 32'd99, 32'd6, 1'b1, 5'd13);
    tick(); in_valid_i = 1'b0;
    chk_out("ori", 1'b1, 32'd1, 32'd6, 3'b010);
    chk("ori_illegal", 32'(illegal_o), 32'd0);

    // 6: synchronous reset while held in HOLD
    out_ready_i = 1'b0;
    tick();
    chk("pre_rst_valid", 32'(out_valid_o), 32'd1);
    rst_i = 1'b0; #1;
    chk("rst2_in_ready_low", 32'(in_ready_o), 32'd0);
    tick();
    chk_out("rst2", 1'b0, 32'h0, 32'h0, 3'b000);
    chk("rst2_rd", 32'(rd_o), 32'd0);
    chk("rst2_illegal", 32'(illegal_o), 32'd0);
    chk("rst2_in_ready", 32'(in_ready_o), 32'd0);
    rst_i = 1'b1; #1;
    chk("rst2_release_ready", 32'(in_ready_o), 32'd1);
    tick();
    chk("rst2_after_valid", 32'(out_valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
